ysyx_2022040010_dcache_tag_ctrl: RTL and testbench

//  N-way set-associative D-cache tag store with a miss-handling controller. It supersedes the fixed
//  2-way/64-set tag array with parametrised ways, sets and line size, and adds tree-PLRU replacement.
//  It also adds valid bits, invalid-way-first victim choice, a sequenced writeback->refill FSM and a

---
 rtl/ysyx_2022040010_dcache_tag_ctrl_if.sv | 44 ++++
 rtl/ysyx_2022040010_dcache_tag_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_ysyx_2022040010_dcache_tag_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_2022040010_dcache_tag_ctrl_if.sv
// LSU request/response, AXI-bridge writeback/refill and flush signals of the
// D-cache tag controller. The slave modport is the controller's view; master is
// the side that issues requests and serves bridge transfers.
interface ysyx_2022040010_dcache_tag_ctrl_if #(
    parameter int ADDR_W = 64,
    parameter int WAY_W  = 2
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_cache;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_hit;
    logic              resp_uncached;
    logic [WAY_W-1:0]  resp_way;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic              refill_valid;
    logic              refill_ready;
    logic [ADDR_W-1:0] refill_addr;
    logic [WAY_W-1:0]  refill_way;
    logic              refill_done;
    logic              flush_req;
    logic              flush_done;
    logic              stallreq;

    modport slave (
        input  req_valid, req_we, req_cache, req_addr, wb_ready, refill_ready,
               refill_done, flush_req,
        output req_ready, resp_valid, resp_hit, resp_uncached, resp_way,
               wb_valid, wb_addr, refill_valid, refill_addr, refill_way,
               flush_done, stallreq
    );

    modport master (
        output req_valid, req_we, req_cache, req_addr, wb_ready, refill_ready,
               refill_done, flush_req,
        input  req_ready, resp_valid, resp_hit, resp_uncached, resp_way,
               wb_valid, wb_addr, refill_valid, refill_addr, refill_way,
               flush_done, stallreq
    );
endinterface

// File: rtl/ysyx_2022040010_dcache_tag_ctrl.sv
// N-way set-associative D-cache tag store with tree-PLRU replacement, a
// writeback->refill miss sequencer and a whole-cache flush walk.
module ysyx_2022040010_dcache_tag_ctrl #(
    parameter int WAYS     = 4,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 4,
    parameter int ADDR_W   = 64
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_2022040010_dcache_tag_ctrl_if.slave io_bus
);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int SETS   = 2 ** INDEX_W;
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int FCNT_W = INDEX_W + WAY_W;
    localparam logic [FCNT_W-1:0] FCNT_ONE  = {{(FCNT_W-1){1'b0}}, 1'b1};
    localparam logic [FCNT_W-1:0] FCNT_LAST = {FCNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0, S_LOOKUP = 3'd1, S_WB    = 3'd2, S_REFILL = 3'd3,
        S_RWAIT  = 3'd4, S_UPDATE = 3'd5, S_FLUSH = 3'd6, S_FWB    = 3'd7
    } state_t;

    // Victim = walk from the root; a node bit of 0 means the victim is in the lower half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        logic [WAY_W-1:0] way;
        int n;
        way = {WAY_W{1'b0}};
        n   = 0;
        for (int l = 0; l < WAY_W; l++) begin
            way[WAY_W'(WAY_W-1-l)] = bits[WAY_W'(n)];
            n = 2 * n + 1 + int'(bits[WAY_W'(n)]);
        end
        return way;
    endfunction

    // Touch points every node on the way's path away from that way.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] nb;
        logic b;
        int n;
        nb = bits;
        n  = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b = way[WAY_W'(WAY_W-1-l)];
            nb[WAY_W'(n)] = ~b;
            n = 2 * n + 1 + int'(b);
        end
        return nb;
    endfunction

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic                r_cache;
    logic [WAY_W-1:0]    r_victim;
    logic [FCNT_W-1:0]   r_fcnt;
    logic [WAYS-1:0]     r_valid [SETS];
    logic [WAYS-1:0]     r_dirty [SETS];
    logic [WAYS-2:0]     r_plru  [SETS];
    logic [TAG_W-1:0]    r_tag   [SETS][WAYS];

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_fset;
    logic [WAY_W-1:0]    w_fway;
    logic                w_hit, w_has_inv;
    logic [WAY_W-1:0]    w_hit_way, w_inv_way, w_victim;
    logic                w_vic_dirty, w_fent_dirty;
    logic                w_touch_hit, w_upd, w_fclr, w_fwb_ok, w_flush_end;
    logic                w_unused;

    assign w_idx        = r_addr[OFFSET_W +: INDEX_W];
    assign w_tag        = r_addr[ADDR_W-1 -: TAG_W];
    assign w_fset       = r_fcnt[FCNT_W-1 -: INDEX_W];
    assign w_fway       = r_fcnt[WAY_W-1:0];
    assign w_victim     = w_has_inv ? w_inv_way : plru_victim(r_plru[w_idx]);
    assign w_vic_dirty  = r_valid[w_idx][w_victim] & r_dirty[w_idx][w_victim];
    assign w_fent_dirty = r_valid[w_fset][w_fway] & r_dirty[w_fset][w_fway];
    assign w_unused     = ^r_addr[OFFSET_W-1:0];

    // Tag compare across the latched set and lowest-index invalid way search.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = {WAY_W{1'b0}};
        w_has_inv = 1'b0;
        w_inv_way = {WAY_W{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            w_has_inv = w_has_inv | ~r_valid[w_idx][WAY_W'(w)];
            w_inv_way = r_valid[w_idx][WAY_W'(w)] ? w_inv_way : WAY_W'(w);
            w_hit     = w_hit | (r_valid[w_idx][WAY_W'(w)] & (r_tag[w_idx][w] == w_tag));
            w_hit_way = (r_valid[w_idx][WAY_W'(w)] & (r_tag[w_idx][w] == w_tag)) ?
                        WAY_W'(w) : w_hit_way;
        end
    end

    // Next-state logic and the array update strobes for each state.
    always_comb begin
        w_state_nxt = r_state;
        w_touch_hit = 1'b0;
        w_upd       = 1'b0;
        w_fclr      = 1'b0;
        w_fwb_ok    = 1'b0;
        w_flush_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.flush_req)      w_state_nxt = S_FLUSH;
                else if (io_bus.req_valid) w_state_nxt = S_LOOKUP;
                else                       w_state_nxt = S_IDLE;
            end
            S_LOOKUP: begin
                if (!r_cache) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hit) begin
                    w_touch_hit = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_vic_dirty) begin
                    w_state_nxt = S_WB;
                end else begin
                    w_state_nxt = S_REFILL;
                end
            end
            S_WB:     w_state_nxt = io_bus.wb_ready     ? S_REFILL : S_WB;
            S_REFILL: w_state_nxt = io_bus.refill_ready ? S_RWAIT  : S_REFILL;
            S_RWAIT:  w_state_nxt = io_bus.refill_done  ? S_UPDATE : S_RWAIT;
            S_UPDATE: begin
                w_upd       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_FLUSH: begin
                if (w_fent_dirty) begin
                    w_state_nxt = S_FWB;
                end else begin
                    w_fclr = 1'b1;
                    if (r_fcnt == FCNT_LAST) begin
                        w_flush_end = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_FLUSH;
                    end
                end
            end
            S_FWB: begin
                if (io_bus.wb_ready) begin
                    w_fwb_ok    = 1'b1;
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_FWB;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the registered state and the latched request.
    always_comb begin
        io_bus.req_ready     = (r_state == S_IDLE) & ~io_bus.flush_req;
        io_bus.stallreq      = (r_state != S_IDLE);
        io_bus.resp_valid    = 1'b0;
        io_bus.resp_hit      = 1'b0;
        io_bus.resp_uncached = 1'b0;
        io_bus.resp_way      = r_victim;
        io_bus.wb_valid      = (r_state == S_WB) | (r_state == S_FWB);
        io_bus.wb_addr       = {r_tag[w_idx][r_victim], w_idx, {OFFSET_W{1'b0}}};
        io_bus.refill_valid  = (r_state == S_REFILL);
        io_bus.refill_addr   = {w_tag, w_idx, {OFFSET_W{1'b0}}};
        io_bus.refill_way    = r_victim;
        io_bus.flush_done    = w_flush_end;
        if (r_state == S_LOOKUP) begin
            io_bus.resp_valid    = ~r_cache | w_hit;
            io_bus.resp_uncached = ~r_cache;
            io_bus.resp_hit      = r_cache & w_hit;
            io_bus.resp_way      = w_hit_way;
        end else if (r_state == S_UPDATE) begin
            io_bus.resp_valid    = 1'b1;
        end else if (r_state == S_FWB) begin
            io_bus.wb_addr       = {r_tag[w_fset][w_fway], w_fset, {OFFSET_W{1'b0}}};
        end else begin
            io_bus.resp_valid    = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Latch the accepted request; capture the miss victim; step the flush counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= {ADDR_W{1'b0}};
            r_we     <= 1'b0;
            r_cache  <= 1'b0;
            r_victim <= {WAY_W{1'b0}};
            r_fcnt   <= {FCNT_W{1'b0}};
        end else begin
            if (r_state == S_IDLE && io_bus.req_valid && !io_bus.flush_req) begin
                r_addr  <= io_bus.req_addr;
                r_we    <= io_bus.req_we;
                r_cache <= io_bus.req_cache;
            end
            if (r_state == S_LOOKUP) r_victim <= w_victim;
            if (r_state == S_IDLE)   r_fcnt   <= {FCNT_W{1'b0}};
            else if (w_fclr)         r_fcnt   <= r_fcnt + FCNT_ONE;
        end
    end

    // Valid, dirty and PLRU state: hit touch, refill install and flush clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= {WAYS{1'b0}};
                r_dirty[s] <= {WAYS{1'b0}};
                r_plru[s]  <= {(WAYS-1){1'b0}};
            end
        end else begin
            if (w_touch_hit) begin
                r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
                if (r_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
            end
            if (w_upd) begin
                r_plru[w_idx]            <= plru_touch(r_plru[w_idx], r_victim);
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= r_we;
            end
            if (w_fwb_ok) r_dirty[w_fset][w_fway] <= 1'b0;
            if (w_fclr) begin
                r_valid[w_fset][w_fway] <= 1'b0;
                r_dirty[w_fset][w_fway] <= 1'b0;
            end
            if (w_flush_end) begin
                for (int s = 0; s < SETS; s++) r_plru[s] <= {(WAYS-1){1'b0}};
            end
        end
    end

    // Tag array: written only on refill install, contents are don't-care until valid.
    always_ff @(posedge clk) begin
        if (w_upd) r_tag[w_idx][r_victim] <= w_tag;
    end
endmodule

// File: tb/tb_ysyx_2022040010_dcache_tag_ctrl.sv
// Self-checking bench for the D-cache tag controller (WAYS=4, INDEX_W=6, OFFSET_W=4).
module tb_ysyx_2022040010_dcache_tag_ctrl;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    ysyx_2022040010_dcache_tag_ctrl_if #(.ADDR_W(64), .WAY_W(2)) bus ();

    ysyx_2022040010_dcache_tag_ctrl #(.WAYS(4), .INDEX_W(6), .OFFSET_W(4), .ADDR_W(64)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic hit; logic unc; logic [1:0] way; int lat; } resp_t;
    typedef struct { logic [63:0] addr; logic [1:0] way; } rf_t;
    resp_t       exp_resp_q[$];
    logic [63:0] exp_wb_q[$];
    rf_t         exp_rf_q[$];

    task automatic exp_resp(input logic hit, input logic unc, input logic [1:0] way, input int lat);
        resp_t r;
        r.hit = hit; r.unc = unc; r.way = way; r.lat = lat;
        exp_resp_q.push_back(r);
    endtask

    task automatic exp_rf(input logic [63:0] addr, input logic [1:0] way);
        rf_t f;
        f.addr = addr; f.way = way;
        exp_rf_q.push_back(f);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_cache = 1'b0; bus.req_addr = 64'h0;
        bus.wb_ready = 1'b0; bus.refill_ready = 1'b0; bus.refill_done = 1'b0; bus.flush_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue one request and act as the bridge until the response; checks against the scoreboard.
    task automatic run_req(input logic we, input logic cache, input logic [63:0] addr, input string name);
        resp_t       r;
        rf_t         f;
        logic [63:0] wb_exp;
        bit          done, wb_hold, overlap;
        int          rd_cnt;
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s req_ready: got %b expected 1", name, bus.req_ready);
        end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_cache = cache; bus.req_addr = addr;
        @(negedge clk);
        bus.req_valid = 1'b0;
        done = 1'b0; wb_hold = 1'b0; overlap = 1'b0; rd_cnt = -1; wb_exp = 64'h0;
        for (int k = 0; k < 64 && !done; k++) begin
            bus.wb_ready = 1'b0; bus.refill_ready = 1'b0; bus.refill_done = 1'b0;
            if (bus.wb_valid === 1'b1 && bus.refill_valid === 1'b1) overlap = 1'b1;
            if (bus.resp_valid === 1'b1) begin
                done = 1'b1;
                n_tests++;
                if (exp_resp_q.size() == 0) begin
                    n_fail++; $display("FAIL %s resp: unexpected response", name);
                end else begin
                    r = exp_resp_q.pop_front();
                    if (bus.resp_hit !== r.hit || bus.resp_uncached !== r.unc ||
                        (!r.unc && bus.resp_way !== r.way) || (r.lat >= 0 && k != r.lat)) begin
                        n_fail++;
                        $display("FAIL %s resp: got hit=%b unc=%b way=%0d lat=%0d expected hit=%b unc=%b way=%0d lat=%0d",
                                 name, bus.resp_hit, bus.resp_uncached, bus.resp_way, k, r.hit, r.unc, r.way, r.lat);
                    end
                end
            end
            if (bus.wb_valid === 1'b1) begin
                n_tests++;
                if (!wb_hold) begin
                    wb_hold = 1'b1;
                    if (exp_wb_q.size() == 0) begin
                        n_fail++; $display("FAIL %s wb: unexpected wb_addr %h", name, bus.wb_addr);
                    end else begin
                        wb_exp = exp_wb_q.pop_front();
                        if (bus.wb_addr !== wb_exp) begin
                            n_fail++; $display("FAIL %s wb_addr: got %h expected %h", name, bus.wb_addr, wb_exp);
                        end
                    end
                end else begin
                    wb_hold = 1'b0;
                    bus.wb_ready = 1'b1;
                    if (bus.wb_addr !== wb_exp) begin
                        n_fail++; $display("FAIL %s wb_addr held: got %h expected %h", name, bus.wb_addr, wb_exp);
                    end
                end
            end
            if (bus.refill_valid === 1'b1) begin
                n_tests++;
                if (wb_hold || exp_wb_q.size() != 0) begin
                    n_fail++; $display("FAIL %s order: refill before wb done, pending wb %0d expected 0", name, exp_wb_q.size());
                end
                n_tests++;
                if (exp_rf_q.size() == 0) begin
                    n_fail++; $display("FAIL %s refill: unexpected refill_addr %h", name, bus.refill_addr);
                end else begin
                    f = exp_rf_q.pop_front();
                    if (bus.refill_addr !== f.addr || bus.refill_way !== f.way) begin
                        n_fail++; $display("FAIL %s refill: got %h way %0d expected %h way %0d",
                                           name, bus.refill_addr, bus.refill_way, f.addr, f.way);
                    end
                end
                bus.refill_ready = 1'b1;
                bus.refill_done  = 1'b1;   // outside RWAIT, must be ignored
                rd_cnt = 2;
            end else if (rd_cnt == 0) begin
                bus.refill_done = 1'b1;
                rd_cnt = -1;
            end else if (rd_cnt > 0) begin
                rd_cnt--;
            end
            if (!done) @(negedge clk);
        end
        bus.wb_ready = 1'b0; bus.refill_ready = 1'b0; bus.refill_done = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++; $display("FAIL %s timeout: got no resp_valid expected one within 64 cycles", name);
        end
        n_tests++;
        if (exp_wb_q.size() != 0 || exp_rf_q.size() != 0 || overlap) begin
            n_fail++; $display("FAIL %s leftover: got wb=%0d rf=%0d overlap=%b expected 0 0 0",
                               name, exp_wb_q.size(), exp_rf_q.size(), overlap);
        end
        exp_wb_q.delete(); exp_rf_q.delete(); exp_resp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_cache = 1'b0; bus.req_addr = 64'h0;
        bus.wb_ready = 1'b0; bus.refill_ready = 1'b0; bus.refill_done = 1'b0; bus.flush_req = 1'b0;
        #1;
        n_tests++;
        if ({bus.resp_valid, bus.wb_valid, bus.refill_valid, bus.flush_done, bus.stallreq} !== 5'b00000) begin
            n_fail++; $display("FAIL reset outputs: got %b expected 00000",
                               {bus.resp_valid, bus.wb_valid, bus.refill_valid, bus.flush_done, bus.stallreq});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.stallreq !== 1'b0) begin
            n_fail++; $display("FAIL reset ready: got ready=%b stall=%b expected 1 0", bus.req_ready, bus.stallreq);
        end
    endtask

    task automatic test_cold_load();
        exp_rf(64'h8000_0000, 2'd0); exp_resp(1'b0, 1'b0, 2'd0, -1);
        run_req(1'b0, 1'b1, 64'h8000_0000, "cold_load");
        exp_resp(1'b1, 1'b0, 2'd0, 0);
        run_req(1'b0, 1'b1, 64'h8000_0000, "repeat_hit");
        exp_resp(1'b1, 1'b0, 2'd0, 0);
        run_req(1'b0, 1'b1, 64'h8000_0008, "same_line_hit");
    endtask

    task automatic test_plru();
        exp_rf(64'h8000_0400, 2'd1); exp_resp(1'b0, 1'b0, 2'd1, -1);
        run_req(1'b0, 1'b1, 64'h8000_0400, "fill_b");
        exp_rf(64'h8000_0800, 2'd2); exp_resp(1'b0, 1'b0, 2'd2, -1);
        run_req(1'b0, 1'b1, 64'h8000_0800, "fill_c");
        exp_rf(64'h8000_0C00, 2'd3); exp_resp(1'b0, 1'b0, 2'd3, -1);
        run_req(1'b0, 1'b1, 64'h8000_0C00, "fill_d");
        exp_resp(1'b1, 1'b0, 2'd0, 0);
        run_req(1'b0, 1'b1, 64'h8000_0000, "touch_a");
        exp_rf(64'h8000_1000, 2'd2); exp_resp(1'b0, 1'b0, 2'd2, -1);
        run_req(1'b0, 1'b1, 64'h8000_1000, "plru_victim_c");
        exp_resp(1'b1, 1'b0, 2'd3, 0);
        run_req(1'b0, 1'b1, 64'h8000_0C00, "d_survives");
    endtask

    task automatic test_uncached();
        exp_resp(1'b0, 1'b1, 2'd0, 0);
        run_req(1'b0, 1'b0, 64'h1000_0000, "uncached");
        exp_rf(64'h8000_1400, 2'd1); exp_resp(1'b0, 1'b0, 2'd1, -1);
        run_req(1'b0, 1'b1, 64'h8000_1400, "plru_unchanged");
        exp_rf(64'h1000_0000, 2'd2); exp_resp(1'b0, 1'b0, 2'd2, -1);
        run_req(1'b0, 1'b1, 64'h1000_0000, "uncached_not_alloc");
    endtask

    task automatic test_store_evict();
        apply_reset();
        exp_rf(64'h8000_0000, 2'd0); exp_resp(1'b0, 1'b0, 2'd0, -1);
        run_req(1'b0, 1'b1, 64'h8000_0000, "se_load_a");
        exp_resp(1'b1, 1'b0, 2'd0, 0);
        run_req(1'b1, 1'b1, 64'h8000_0008, "se_store_hit");
        for (int i = 1; i < 4; i++) begin
            exp_rf(64'h8000_0000 + 64'(i) * 64'h400, 2'(i)); exp_resp(1'b0, 1'b0, 2'(i), -1);
            run_req(1'b0, 1'b1, 64'h8000_0000 + 64'(i) * 64'h400, "se_fill");
        end
        exp_wb_q.push_back(64'h8000_0000);
        exp_rf(64'h8000_1000, 2'd0); exp_resp(1'b0, 1'b0, 2'd0, -1);
        run_req(1'b0, 1'b1, 64'h8000_1000, "se_evict_dirty");
        exp_rf(64'h8000_1400, 2'd2); exp_resp(1'b0, 1'b0, 2'd2, -1);
        run_req(1'b1, 1'b1, 64'h8000_1400, "se_store_miss");
        exp_rf(64'h8000_1800, 2'd1); exp_resp(1'b0, 1'b0, 2'd1, -1);
        run_req(1'b0, 1'b1, 64'h8000_1800, "se_load_g");
        exp_rf(64'h8000_1C00, 2'd3); exp_resp(1'b0, 1'b0, 2'd3, -1);
        run_req(1'b0, 1'b1, 64'h8000_1C00, "se_load_h");
        exp_rf(64'h8000_2000, 2'd0); exp_resp(1'b0, 1'b0, 2'd0, -1);
        run_req(1'b0, 1'b1, 64'h8000_2000, "se_refill_load_clean");
        exp_wb_q.push_back(64'h8000_1400);
        exp_rf(64'h8000_2400, 2'd2); exp_resp(1'b0, 1'b0, 2'd2, -1);
        run_req(1'b0, 1'b1, 64'h8000_2400, "se_refill_store_dirty");
    endtask

    task automatic test_flush();
        int  nwb, done_k;
        logic [63:0] e;
        apply_reset();
        exp_rf(64'h8000_0000, 2'd0); exp_resp(1'b0, 1'b0, 2'd0, -1);
        run_req(1'b1, 1'b1, 64'h8000_0000, "fl_store0");
        exp_rf(64'h8000_0010, 2'd0); exp_resp(1'b0, 1'b0, 2'd0, -1);
        run_req(1'b1, 1'b1, 64'h8000_0010, "fl_store1");
        exp_rf(64'h8000_0020, 2'd0); exp_resp(1'b0, 1'b0, 2'd0, -1);
        run_req(1'b0, 1'b1, 64'h8000_0020, "fl_load2");
        exp_wb_q.push_back(64'h8000_0000);
        exp_wb_q.push_back(64'h8000_0010);
        bus.flush_req = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush req_ready: got %b expected 0", bus.req_ready);
        end
        nwb = 0; done_k = -1;
        for (int k = 1; k <= 600 && done_k < 0; k++) begin
            @(negedge clk);
            bus.flush_req = 1'b0;          // level dropped mid-walk: walk continues
            bus.wb_ready  = 1'b0;
            if (bus.wb_valid === 1'b1) begin
                nwb++;
                n_tests++;
                e = (exp_wb_q.size() != 0) ? exp_wb_q.pop_front() : 64'hDEAD;
                if (bus.wb_addr !== e) begin
                    n_fail++; $display("FAIL flush wb_addr: got %h expected %h", bus.wb_addr, e);
                end
                bus.wb_ready = 1'b1;
            end
            if (bus.flush_done === 1'b1) done_k = k;
        end
        bus.wb_ready = 1'b0;
        n_tests++;
        if (nwb != 2) begin
            n_fail++; $display("FAIL flush wb count: got %0d expected 2", nwb);
        end
        n_tests++;
        if (done_k < 256 || done_k > 264) begin
            n_fail++; $display("FAIL flush_done cycle: got %0d expected 256..264", done_k);
        end
        @(negedge clk);
        n_tests++;
        if (bus.flush_done !== 1'b0 || bus.stallreq !== 1'b0) begin
            n_fail++; $display("FAIL flush end: got done=%b stall=%b expected 0 0", bus.flush_done, bus.stallreq);
        end
        exp_wb_q.delete();
        exp_rf(64'h8000_0000, 2'd0); exp_resp(1'b0, 1'b0, 2'd0, -1);
        run_req(1'b0, 1'b1, 64'h8000_0000, "fl_miss_after");
        exp_rf(64'h8000_0020, 2'd0); exp_resp(1'b0, 1'b0, 2'd0, -1);
        run_req(1'b0, 1'b1, 64'h8000_0020, "fl_clean_invalidated");
    endtask

    task automatic test_reset_midop();
        bit seen;
        exp_resp(1'b1, 1'b0, 2'd0, 0);
        run_req(1'b0, 1'b1, 64'h8000_0000, "rm_hit_before");
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_cache = 1'b1; bus.req_addr = 64'h8000_0040;
        @(negedge clk);
        bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            if (bus.refill_valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        n_tests++;
        if (!seen || bus.refill_addr !== 64'h8000_0040) begin
            n_fail++; $display("FAIL rm refill: got seen=%b addr %h expected 1 8000_0040", seen, bus.refill_addr);
        end
        bus.refill_ready = 1'b1;
        @(negedge clk);
        bus.refill_ready = 1'b0;
        n_tests++;
        if (bus.stallreq !== 1'b1 || bus.refill_valid !== 1'b0) begin
            n_fail++; $display("FAIL rm rwait: got stall=%b refill_valid=%b expected 1 0", bus.stallreq, bus.refill_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.stallreq !== 1'b0 || bus.refill_valid !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rm async reset: got stall=%b refill=%b resp=%b expected 0 0 0",
                               bus.stallreq, bus.refill_valid, bus.resp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.refill_done = 1'b1;            // late completion of the abandoned transfer
        @(negedge clk);
        bus.refill_done = 1'b0;
        n_tests++;
        if (bus.stallreq !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rm stray done: got stall=%b resp=%b expected 0 0", bus.stallreq, bus.resp_valid);
        end
        exp_rf(64'h8000_0000, 2'd0); exp_resp(1'b0, 1'b0, 2'd0, -1);
        run_req(1'b0, 1'b1, 64'h8000_0000, "rm_miss_after");
    endtask

    initial begin
        clk = 1'b0;
        n_tests = 0;
        n_fail = 0;
        test_reset();
        test_cold_load();
        test_plru();
        test_uncached();
        test_store_evict();
        test_flush();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
